// File: rtl/mips_hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module   : mips_hazard_ctrl
// Purpose  : Pipeline hazard control for the 5-stage MIPS_32 core. Tracks the
//            destination tags of in-flight instructions and produces EX
//            forwarding selects, load-use stalls, branch flushes and a
//            retired-instruction counter.
// Options  : `define HAZARD_PERF_CNT_EN to build the stall/flush counters.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mips_hazard_ctrl #(
  parameter int AW         = 5,
  parameter int CNT_W      = 32,
  parameter int FORWARDING = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_id_valid,
  input  logic [AW-1:0]    i_id_rs,
  input  logic [AW-1:0]    i_id_rt,
  input  logic             i_id_use_rs,
  input  logic             i_id_use_rt,
  input  logic             i_id_reg_write,
  input  logic [AW-1:0]    i_id_wr_addr,
  input  logic             i_id_mem_read,
  input  logic             i_mem_branch_taken,
  output logic             o_stall,
  output logic             o_bubble_ex,
  output logic             o_flush,
  output logic [1:0]       o_fwd_a,
  output logic [1:0]       o_fwd_b,
  output logic [CNT_W-1:0] o_retired,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  // EX tag carries the sources as well so forwarding can be resolved in EX.
  logic          r_ex_valid, r_ex_rw, r_ex_mr, r_ex_use_rs, r_ex_use_rt;
  logic [AW-1:0] r_ex_wa, r_ex_rs, r_ex_rt;
  logic          r_mem_valid, r_mem_rw;
  logic [AW-1:0] r_mem_wa;
  logic          r_wb_valid, r_wb_rw;
  logic [AW-1:0] r_wb_wa;
  logic [CNT_W-1:0] r_retired;
  logic          w_hazard;

  // A tag produces R when it is a live register write to R; r0 never counts
  // when it is hard-wired.
  function automatic logic f_writes(input logic v, input logic rw,
                                    input logic [AW-1:0] wa,
                                    input logic [AW-1:0] r);
    return v && rw && (wa == r) && !((ZERO_REG != 0) && (r == '0));
  endfunction

  assign o_flush     = i_mem_branch_taken;
  // A taken branch kills the stalled instruction anyway, so flush wins.
  assign o_stall     = i_id_valid && w_hazard && !i_mem_branch_taken;
  assign o_bubble_ex = o_stall;
  assign o_retired   = r_retired;

  generate
    if (FORWARDING != 0) begin : g_fwd
      // Forward selects for the EX operands (MEM beats WB) and load-use detect.
      always_comb begin
        o_fwd_a = 2'b00;
        o_fwd_b = 2'b00;
        if (r_ex_valid && r_ex_use_rs) begin
          if (f_writes(r_mem_valid, r_mem_rw, r_mem_wa, r_ex_rs))   o_fwd_a = 2'b01;
          else if (f_writes(r_wb_valid, r_wb_rw, r_wb_wa, r_ex_rs)) o_fwd_a = 2'b10;
        end
        if (r_ex_valid && r_ex_use_rt) begin
          if (f_writes(r_mem_valid, r_mem_rw, r_mem_wa, r_ex_rt))   o_fwd_b = 2'b01;
          else if (f_writes(r_wb_valid, r_wb_rw, r_wb_wa, r_ex_rt)) o_fwd_b = 2'b10;
        end
        w_hazard = r_ex_mr &&
                   ((i_id_use_rs && f_writes(r_ex_valid, r_ex_rw, r_ex_wa, i_id_rs)) ||
                    (i_id_use_rt && f_writes(r_ex_valid, r_ex_rw, r_ex_wa, i_id_rt)));
      end
    end else begin : g_nofwd
      // No bypass paths: any in-flight producer of a used source stalls ID.
      always_comb begin
        o_fwd_a  = 2'b00;
        o_fwd_b  = 2'b00;
        w_hazard = (i_id_use_rs && (f_writes(r_ex_valid,  r_ex_rw,  r_ex_wa,  i_id_rs) ||
                                    f_writes(r_mem_valid, r_mem_rw, r_mem_wa, i_id_rs) ||
                                    f_writes(r_wb_valid,  r_wb_rw,  r_wb_wa,  i_id_rs))) ||
                   (i_id_use_rt && (f_writes(r_ex_valid,  r_ex_rw,  r_ex_wa,  i_id_rt) ||
                                    f_writes(r_mem_valid, r_mem_rw, r_mem_wa, i_id_rt) ||
                                    f_writes(r_wb_valid,  r_wb_rw,  r_wb_wa,  i_id_rt)));
      end
    end
  endgenerate

  // Advance the stage tags; stall bubbles EX, flush also kills MEM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex_valid  <= 1'b0;
      r_ex_rw     <= 1'b0;
      r_ex_mr     <= 1'b0;
      r_ex_use_rs <= 1'b0;
      r_ex_use_rt <= 1'b0;
      r_ex_wa     <= '0;
      r_ex_rs     <= '0;
      r_ex_rt     <= '0;
      r_mem_valid <= 1'b0;
      r_mem_rw    <= 1'b0;
      r_mem_wa    <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_rw     <= 1'b0;
      r_wb_wa     <= '0;
    end else begin
      r_ex_valid  <= i_id_valid && !o_stall && !o_flush;
      r_ex_rw     <= i_id_reg_write;
      r_ex_mr     <= i_id_mem_read;
      r_ex_use_rs <= i_id_use_rs;
      r_ex_use_rt <= i_id_use_rt;
      r_ex_wa     <= i_id_wr_addr;
      r_ex_rs     <= i_id_rs;
      r_ex_rt     <= i_id_rt;
      r_mem_valid <= r_ex_valid && !o_flush;
      r_mem_rw    <= r_ex_rw;
      r_mem_wa    <= r_ex_wa;
      r_wb_valid  <= r_mem_valid;
      r_wb_rw     <= r_mem_rw;
      r_wb_wa     <= r_mem_wa;
    end
  end

  // Count every instruction that reaches WB.
  always_ff @(posedge clk) begin
    if (!rst_n) r_retired <= '0;
    else if (r_wb_valid) r_retired <= r_retired + 1'b1;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  // Performance counters: cycles stalled and cycles flushing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (o_stall) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (o_flush) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mips_hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_mips_hazard_ctrl
// Purpose  : Directed bench for mips_hazard_ctrl. Three instances share the
//            stimulus: defaults, ZERO_REG=0, and FORWARDING=0 with CNT_W=4.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mips_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic       id_valid, id_use_rs, id_use_rt, id_reg_write, id_mem_read, br;
  logic [4:0] id_rs, id_rt, id_wr_addr;

  logic        d0_stall, d0_bub, d0_flush;
  logic [1:0]  d0_fa, d0_fb;
  logic [31:0] d0_ret, d0_sc, d0_fc;
  logic        dz_stall, dz_bub, dz_flush;
  logic [1:0]  dz_fa, dz_fb;
  logic [31:0] dz_ret, dz_sc, dz_fc;
  logic        dn_stall, dn_bub, dn_flush;
  logic [1:0]  dn_fa, dn_fb;
  logic [3:0]  dn_ret, dn_sc, dn_fc;

  int checks = 0;
  int errors = 0;

  mips_hazard_ctrl u_d0 (
    .clk(clk), .rst_n(rst_n), .i_id_valid(id_valid), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_use_rs(id_use_rs), .i_id_use_rt(id_use_rt), .i_id_reg_write(id_reg_write),
    .i_id_wr_addr(id_wr_addr), .i_id_mem_read(id_mem_read), .i_mem_branch_taken(br),
    .o_stall(d0_stall), .o_bubble_ex(d0_bub), .o_flush(d0_flush), .o_fwd_a(d0_fa),
    .o_fwd_b(d0_fb), .o_retired(d0_ret), .o_stall_cnt(d0_sc), .o_flush_cnt(d0_fc));

  mips_hazard_ctrl #(.ZERO_REG(0)) u_dz (
    .clk(clk), .rst_n(rst_n), .i_id_valid(id_valid), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_use_rs(id_use_rs), .i_id_use_rt(id_use_rt), .i_id_reg_write(id_reg_write),
    .i_id_wr_addr(id_wr_addr), .i_id_mem_read(id_mem_read), .i_mem_branch_taken(br),
    .o_stall(dz_stall), .o_bubble_ex(dz_bub), .o_flush(dz_flush), .o_fwd_a(dz_fa),
    .o_fwd_b(dz_fb), .o_retired(dz_ret), .o_stall_cnt(dz_sc), .o_flush_cnt(dz_fc));

  mips_hazard_ctrl #(.FORWARDING(0), .CNT_W(4)) u_dn (
    .clk(clk), .rst_n(rst_n), .i_id_valid(id_valid), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_use_rs(id_use_rs), .i_id_use_rt(id_use_rt), .i_id_reg_write(id_reg_write),
    .i_id_wr_addr(id_wr_addr), .i_id_mem_read(id_mem_read), .i_mem_branch_taken(br),
    .o_stall(dn_stall), .o_bubble_ex(dn_bub), .o_flush(dn_flush), .o_fwd_a(dn_fa),
    .o_fwd_b(dn_fb), .o_retired(dn_ret), .o_stall_cnt(dn_sc), .o_flush_cnt(dn_fc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one ID-stage instruction, then let the combinational outputs settle.
  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic rw,
                        input logic [4:0] wa, input logic mr);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_reg_write = rw; id_wr_addr = wa; id_mem_read = mr;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    br    = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
  endtask

  logic [31:0] exp_pc1, exp_pc3;

  initial begin
`ifdef HAZARD_PERF_CNT_EN
    exp_pc1 = 32'd1;
    exp_pc3 = 32'd3;
`else
    exp_pc1 = 32'd0;
    exp_pc3 = 32'd0;
`endif
    // ---- reset state ----
    do_reset();
    chk("rst_stall", {31'd0, d0_stall}, 32'd0);
    chk("rst_bubble", {31'd0, d0_bub}, 32'd0);
    chk("rst_fwd", {28'd0, d0_fa, d0_fb}, 32'd0);
    chk("rst_retired", d0_ret, 32'd0);
    chk("rst_flush_cnt", d0_fc, 32'd0);
    rst_n = 1'b0; br = 1'b1; #1;
    chk("rst_flush_follows", {31'd0, d0_flush}, 32'd1);
    br = 1'b0; rst_n = 1'b1;

    // ---- ADD r3 ; SUB r6,r3,r1 ; OR r7,r1,r3 ----
    do_reset();
    set_id(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0); tick();
    set_id(1, 5'd3, 5'd1, 1, 1, 1, 5'd6, 0);
    chk("alu_no_stall", {31'd0, d0_stall}, 32'd0);
    tick();
    chk("fwd_a_mem", {30'd0, d0_fa}, 32'd1);
    chk("fwd_b_none", {30'd0, d0_fb}, 32'd0);
    set_id(1, 5'd1, 5'd3, 1, 1, 1, 5'd7, 0); tick();
    chk("fwd_b_wb", {30'd0, d0_fb}, 32'd2);
    chk("fwd_a_none", {30'd0, d0_fa}, 32'd0);

    // ---- LW r4 ; ADD r5,r4,r1 : one bubble then WB forward ----
    do_reset();
    set_id(1, 5'd1, 5'd0, 1, 0, 1, 5'd4, 1); tick();
    set_id(1, 5'd4, 5'd1, 1, 1, 1, 5'd5, 0);
    chk("lu_stall", {31'd0, d0_stall}, 32'd1);
    chk("lu_bubble", {31'd0, d0_bub}, 32'd1);
    tick();
    chk("lu_stall_released", {31'd0, d0_stall}, 32'd0);
    chk("lu_stall_cnt", d0_sc, exp_pc1);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    chk("lu_fwd_a_wb", {30'd0, d0_fa}, 32'd2);
    chk("lu_fwd_b", {30'd0, d0_fb}, 32'd0);
    chk("lu_no_stall", {31'd0, d0_stall}, 32'd0);
    tick(); tick(); tick(); tick();
    chk("lu_retired", d0_ret, 32'd2);

    // ---- ADD r0 ; consumer of r0 ----
    do_reset();
    set_id(1, 5'd1, 5'd2, 1, 1, 1, 5'd0, 0); tick();
    set_id(1, 5'd0, 5'd0, 1, 1, 1, 5'd8, 0);
    chk("r0_no_stall", {31'd0, d0_stall}, 32'd0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    chk("r0_fwd_hardwired", {28'd0, d0_fa, d0_fb}, 32'd0);
    chk("r0_fwd_a_nozero", {30'd0, dz_fa}, 32'd1);

    // ---- ADD r3 ; LW r4 ; ADD r?,r4,r3 with branch taken ----
    do_reset();
    set_id(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0); tick();
    set_id(1, 5'd1, 5'd0, 1, 0, 1, 5'd4, 1); tick();
    set_id(1, 5'd4, 5'd3, 1, 1, 1, 5'd9, 0);
    chk("br_pre_stall", {31'd0, d0_stall}, 32'd1);
    br = 1'b1; #1;
    chk("br_flush", {31'd0, d0_flush}, 32'd1);
    chk("br_stall_masked", {31'd0, d0_stall}, 32'd0);
    chk("br_bubble_masked", {31'd0, d0_bub}, 32'd0);
    tick();
    br = 1'b0; #1;
    chk("br_after_no_stall", {31'd0, d0_stall}, 32'd0);
    chk("br_flush_cnt", d0_fc, exp_pc1);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    chk("br_no_fwd_flushed", {28'd0, d0_fa, d0_fb}, 32'd0);

    // ---- FORWARDING=0: ADD r3 ; SUB r6,r3,r1 stalls three cycles ----
    do_reset();
    set_id(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0); tick();
    set_id(1, 5'd3, 5'd1, 1, 1, 1, 5'd6, 0);
    for (int k = 0; k < 3; k++) begin
      chk("nf_stall", {31'd0, dn_stall}, 32'd1);
      chk("nf_fwd", {28'd0, dn_fa, dn_fb}, 32'd0);
      tick();
    end
    chk("nf_released", {31'd0, dn_stall}, 32'd0);
    chk("nf_stall_cnt", {28'd0, dn_sc}, exp_pc3);

    // ---- reset during a stall with retired=7 ----
    do_reset();
    for (int k = 0; k < 9; k++) begin
      set_id(1, 5'd1, 5'd2, 1, 1, 0, 5'd0, 0); tick();
    end
    set_id(1, 5'd1, 5'd0, 1, 0, 1, 5'd4, 1); tick();
    set_id(1, 5'd4, 5'd1, 1, 1, 1, 5'd5, 0);
    chk("rs7_retired", d0_ret, 32'd7);
    chk("rs7_stall", {31'd0, d0_stall}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("rs7_stall_cleared", {31'd0, d0_stall}, 32'd0);
    chk("rs7_retired_cleared", d0_ret, 32'd0);
    chk("rs7_stall_cnt_cleared", d0_sc, 32'd0);
    rst_n = 1'b1;

    // ---- 16 retirements wrap a 4-bit counter ----
    do_reset();
    for (int k = 0; k < 16; k++) begin
      set_id(1, 5'd1, 5'd2, 1, 1, 0, 5'd0, 0); tick();
    end
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("wrap_pre", {28'd0, dn_ret}, 32'd15);
    tick();
    chk("wrap_zero", {28'd0, dn_ret}, 32'd0);
    chk("wrap_wide", d0_ret, 32'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mips_hazard_ctrl.md
Name: mips_hazard_ctrl

Overview:
- Parametrised pipeline-control block for the 5-stage MIPS_32 core (IF/ID/EX/MEM/WB).
- Tracks destination-register tags of in-flight instructions, then drives:
  - EX-stage forwarding selects
  - load-use stalls
  - branch flushes
  - a retired-instruction counter
- Sits beside the ID/EX/MEM/WB stage buffers; the stage buffers consume its stall and flush outputs.

Parameters:
- AW, 5: register-address width.
- CNT_W, 32: retire and performance counter width.
- FORWARDING, 1: 1 = forward from MEM/WB; 0 = stall on every RAW hazard until the producer leaves WB.
- ZERO_REG, 1: 1 = register 0 is hard-wired, never a hazard source or forwarded.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  AW  ID source A.
- id_rt  in  AW  ID source B.
- id_use_rs  in  1  instruction reads rs.
- id_use_rt  in  1  instruction reads rt.
- id_reg_write  in  1  ID instruction writes a register.
- id_wr_addr  in  AW  ID destination (post-RegDst mux).
- id_mem_read  in  1  ID instruction is a load.
- mem_branch_taken  in  1  branch resolved taken in MEM (Branch AND zero_flag).
- stall  out  1  hold PC and IF/ID buffer.
- bubble_ex  out  1  load control zeros into ID/EX buffer.
- flush  out  1  invalidate IF/ID, ID/EX, EX/MEM contents.
- fwd_a  out  2  EX operand A select.
- fwd_b  out  2  EX operand B select.
- retired  out  CNT_W  instructions completed in WB.
- stall_cnt  out  CNT_W  stall cycles (feature-gated).
- flush_cnt  out  CNT_W  flush events (feature-gated).

Behaviour:
- Internal tag registers exist for the EX, MEM and WB stages. Each tag holds {valid, reg_write, wr_addr, mem_read}. The EX tag additionally holds {rs, rt, use_rs, use_rt}.
- Each rising clk, with no stall/flush:
  - EX tag <= ID inputs (valid = id_valid)
  - MEM tag <= EX tag
  - WB tag <= MEM tag
- Producer definition: a tag "writes R" when valid & reg_write & wr_addr==R & !(ZERO_REG & R==0).
- Forwarding (combinational from EX tag, FORWARDING=1). For each EX source used:
  - select 2'b01 (EX/MEM ALU result) if the MEM tag writes it;
  - else 2'b10 (WB mux value) if the WB tag writes it;
  - else 2'b00 (register file).
  - MEM takes priority over WB.
  - With FORWARDING=0, fwd_a and fwd_b are constant 00.
- Stall condition, combinational, qualified by id_valid:
  - FORWARDING=1: the EX tag is a load that writes an ID source which is used (load-use).
  - FORWARDING=0: the EX, MEM or WB tag writes a used ID source.
  - The register file is write-before-read, so WB never causes a stall with forwarding on.
- On stall: assert stall = bubble_ex = 1. At the next edge:
  - EX tag <= invalid
  - MEM and WB advance
  - ID inputs are held by the datapath and re-evaluated.
- Load-use therefore costs exactly 1 bubble. Without forwarding, a stall lasts until the producer has left WB, at most 3 cycles.
- Flush: flush = mem_branch_taken. At the next edge:
  - EX tag <= invalid
  - MEM tag <= invalid
  - WB tag <= MEM tag (the branch itself completes)
- Flush has priority over stall: stall and bubble_ex are forced to 0 while flush=1.
- retired increments by 1 each cycle the WB tag is valid; it wraps modulo 2^CNT_W.
- Reset (rst_n=0 at an edge):
  - all tags invalid
  - retired, stall_cnt, flush_cnt = 0
  - consequently stall=0, bubble_ex=0, fwd_a=fwd_b=00
  - flush follows its input.
- Reset asserted mid-stall or mid-flush cancels it in the same edge; no state survives.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cnt increments each cycle with stall=1.
  - flush_cnt increments each cycle with flush=1.
  - Both wrap and both reset to 0.
- Undefined: the counters are not synthesised; stall_cnt and flush_cnt are driven constant 0 (ports remain).

Test Plan:
- ADD r3 in EX, then SUB using r3 as rs next -> cycle the SUB enters EX: fwd_a=01, stall=0; following instruction using r3 as rt -> fwd_b=10.
- LW r4 followed by ADD r5,r4,r1 -> stall=bubble_ex=1 for exactly one cycle, then fwd_a=10 for the ADD in EX; retired counts 2 after both complete.
- ADD r0,... followed by consumer of r0 (ZERO_REG=1) -> fwd 00, no stall; with ZERO_REG=0 -> fwd_a=01.
- Branch taken in MEM while a load-use hazard exists in ID -> flush=1, stall=0; next cycle EX and MEM tags invalid; no forwarding from flushed instructions.
- FORWARDING=0, dependent ADD immediately after producer -> stall high 3 consecutive cycles, then released; fwd always 00.
- Assert rst_n=0 during a stall with retired=7 -> next cycle stall=0, retired=0, stall_cnt=0 (with HAZARD_PERF_CNT_EN); counter wrap checked with CNT_W=4: 16 retirements -> retired=0.
